// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-to-one imem/dmem arbiter onto a single memory port with in-order response steering
module mem_arbiter #(
    parameter int DEPTH      = 4,
    parameter int MAX_STREAK = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         imem_req_valid,
    output logic                         imem_req_ready,
    input  logic [31:0]                  imem_req_bits_addr,
    input  logic [31:0]                  imem_req_bits_data,
    input  logic                         imem_req_bits_fcn,
    input  logic [2:0]                   imem_req_bits_typ,
    input  logic                         dmem_req_valid,
    output logic                         dmem_req_ready,
    input  logic [31:0]                  dmem_req_bits_addr,
    input  logic [31:0]                  dmem_req_bits_data,
    input  logic                         dmem_req_bits_fcn,
    input  logic [2:0]                   dmem_req_bits_typ,
    output logic                         imem_resp_valid,
    output logic [31:0]                  imem_resp_bits_data,
    output logic                         dmem_resp_valid,
    output logic [31:0]                  dmem_resp_bits_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [31:0]                  mem_req_bits_addr,
    output logic [31:0]                  mem_req_bits_data,
    output logic                         mem_req_bits_fcn,
    output logic [2:0]                   mem_req_bits_typ,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  mem_resp_bits_data,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         resp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [DEPTH-1:0] owner_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SW-1:0]    streak;
    logic             full;
    logic             empty;
    logic             grant_imem;
    logic             accept_ok;
    logic             issue;
    logic             pop;
    logic             orphan;
    logic             head_dmem;

    assign full  = (outstanding == CW'(DEPTH));
    assign empty = (outstanding == '0);

    // dmem wins by default; imem is forced ahead once dmem has had MAX_STREAK grants in a row
    assign grant_imem = !dmem_req_valid || ((streak == SW'(MAX_STREAK)) && imem_req_valid);

    assign mem_req_valid     = (imem_req_valid || dmem_req_valid) && !full && !reset;
    assign mem_req_bits_addr = grant_imem ? imem_req_bits_addr : dmem_req_bits_addr;
    assign mem_req_bits_data = grant_imem ? imem_req_bits_data : dmem_req_bits_data;
    assign mem_req_bits_fcn  = grant_imem ? imem_req_bits_fcn  : dmem_req_bits_fcn;
    assign mem_req_bits_typ  = grant_imem ? imem_req_bits_typ  : dmem_req_bits_typ;

    assign accept_ok      = mem_req_ready && !full && !reset;
    assign imem_req_ready = accept_ok && grant_imem;
    assign dmem_req_ready = accept_ok && !grant_imem;

    assign issue     = mem_req_valid && mem_req_ready;
    assign head_dmem = owner_q[rd_ptr];
    assign pop       = mem_resp_valid && !empty && !reset;
    assign orphan    = mem_resp_valid && empty && !reset;

    assign imem_resp_valid     = pop && !head_dmem;
    assign dmem_resp_valid     = pop && head_dmem;
    assign imem_resp_bits_data = mem_resp_bits_data;
    assign dmem_resp_bits_data = mem_resp_bits_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            streak      <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (issue) begin
                owner_q[wr_ptr] <= !grant_imem;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (issue && !pop) begin
                outstanding <= outstanding + CW'(1);
            end else if (!issue && pop) begin
                outstanding <= outstanding - CW'(1);
            end
            if (orphan) begin
                resp_err <= 1'b1;
            end
            // streak only measures how long imem has been kept waiting
            if (!imem_req_valid || (issue && grant_imem)) begin
                streak <= '0;
            end else if (issue && streak != SW'(MAX_STREAK)) begin
                streak <= streak + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid, dmem_req_valid;
    logic        imem_req_ready, dmem_req_ready;
    logic [31:0] imem_req_bits_addr, imem_req_bits_data;
    logic [31:0] dmem_req_bits_addr, dmem_req_bits_data;
    logic        imem_req_bits_fcn, dmem_req_bits_fcn;
    logic [2:0]  imem_req_bits_typ, dmem_req_bits_typ;
    logic        imem_resp_valid, dmem_resp_valid;
    logic [31:0] imem_resp_bits_data, dmem_resp_bits_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_bits_addr, mem_req_bits_data;
    logic        mem_req_bits_fcn;
    logic [2:0]  mem_req_bits_typ;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_bits_data;
    logic [2:0]  outstanding;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.DEPTH(4), .MAX_STREAK(3)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_bits_addr(imem_req_bits_addr), .imem_req_bits_data(imem_req_bits_data),
        .imem_req_bits_fcn(imem_req_bits_fcn), .imem_req_bits_typ(imem_req_bits_typ),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_bits_addr(dmem_req_bits_addr), .dmem_req_bits_data(dmem_req_bits_data),
        .dmem_req_bits_fcn(dmem_req_bits_fcn), .dmem_req_bits_typ(dmem_req_bits_typ),
        .imem_resp_valid(imem_resp_valid), .imem_resp_bits_data(imem_resp_bits_data),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_bits_data(dmem_resp_bits_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_bits_addr(mem_req_bits_addr), .mem_req_bits_data(mem_req_bits_data),
        .mem_req_bits_fcn(mem_req_bits_fcn), .mem_req_bits_typ(mem_req_bits_typ),
        .mem_resp_valid(mem_resp_valid), .mem_resp_bits_data(mem_resp_bits_data),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] order;

    initial begin
        reset = 1'b1;
        imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
        imem_req_bits_addr = 32'h1000; imem_req_bits_data = 32'h0;
        imem_req_bits_fcn = 1'b0; imem_req_bits_typ = 3'd2;
        dmem_req_bits_addr = 32'h2000; dmem_req_bits_data = 32'hA5A5_0000;
        dmem_req_bits_fcn = 1'b1; dmem_req_bits_typ = 3'd1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_bits_data = 32'h0;

        // reset held for two cycles with everything asking
        for (int k = 0; k < 2; k++) begin
            #2;
            check("rst_mem_req_valid", mem_req_valid, 0);
            check("rst_imem_ready", imem_req_ready, 0);
            check("rst_dmem_ready", dmem_req_ready, 0);
            step;
        end
        check("rst_outstanding", outstanding, 0);
        check("rst_resp_err", resp_err, 0);
        reset = 1'b0; imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        step;

        // single imem read
        imem_req_valid = 1'b1; imem_req_bits_addr = 32'h100;
        #1;
        check("single_mem_valid", mem_req_valid, 1);
        check("single_addr", mem_req_bits_addr, 32'h100);
        check("single_fcn", mem_req_bits_fcn, 0);
        check("single_typ", mem_req_bits_typ, 3'd2);
        check("single_imem_ready", imem_req_ready, 1);
        check("single_dmem_ready", dmem_req_ready, 0);
        step;
        imem_req_valid = 1'b0;
        check("single_out1", outstanding, 1);
        step;
        mem_resp_valid = 1'b1; mem_resp_bits_data = 32'hDEADBEEF;
        #1;
        check("single_imem_resp_valid", imem_resp_valid, 1);
        check("single_dmem_resp_valid", dmem_resp_valid, 0);
        check("single_imem_resp_data", imem_resp_bits_data, 32'hDEADBEEF);
        step;
        mem_resp_valid = 1'b0;
        check("single_out0", outstanding, 0);

        // contention: d,d,d,i,d,d,d,i with one-cycle memory latency
        imem_req_bits_addr = 32'h1000;
        order = 8'h88;
        imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_resp_valid = (k > 0);
            mem_resp_bits_data = 32'h100 + k;
            #1;
            check($sformatf("cont_imem_ready_%0d", k), imem_req_ready, order[k]);
            check($sformatf("cont_dmem_ready_%0d", k), dmem_req_ready, !order[k]);
            check($sformatf("cont_addr_%0d", k), mem_req_bits_addr, order[k] ? 32'h1000 : 32'h2000);
            if (k > 0) begin
                check($sformatf("cont_iresp_%0d", k), imem_resp_valid, order[k-1]);
                check($sformatf("cont_dresp_%0d", k), dmem_resp_valid, !order[k-1]);
            end
            step;
        end
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0; mem_resp_valid = 1'b1;
        #1;
        check("cont_last_iresp", imem_resp_valid, 1);
        step;
        mem_resp_valid = 1'b0;
        check("cont_out0", outstanding, 0);

        // full FIFO with dmem streaming
        dmem_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("full_dready_%0d", k), dmem_req_ready, 1);
            step;
        end
        check("full_out4", outstanding, 4);
        check("full_dready_blocked", dmem_req_ready, 0);
        check("full_mem_valid", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_bits_data = 32'h55;
        #1;
        check("full_pop_no_issue", dmem_req_ready, 0);
        check("full_dresp_valid", dmem_resp_valid, 1);
        check("full_iresp_valid", imem_resp_valid, 0);
        check("full_dresp_data", dmem_resp_bits_data, 32'h55);
        step;
        mem_resp_valid = 1'b0;
        check("full_out3", outstanding, 3);
        check("full_resume", dmem_req_ready, 1);
        step;
        dmem_req_valid = 1'b0;
        check("full_out4b", outstanding, 4);
        mem_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) step;
        mem_resp_valid = 1'b0;
        check("full_drained", outstanding, 0);

        // interleaved i,d,i,d then responses 1..4
        for (int k = 0; k < 4; k++) begin
            imem_req_valid = (k % 2 == 0); dmem_req_valid = (k % 2 == 1);
            #1;
            if (k == 1) begin
                check("inter_wr_fcn", mem_req_bits_fcn, 1);
                check("inter_wr_data", mem_req_bits_data, 32'hA5A5_0000);
            end
            step;
        end
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_bits_data = 32'(k + 1);
            #1;
            check($sformatf("inter_iresp_%0d", k), imem_resp_valid, (k % 2 == 0));
            check($sformatf("inter_dresp_%0d", k), dmem_resp_valid, (k % 2 == 1));
            check($sformatf("inter_data_%0d", k),
                  (k % 2 == 0) ? imem_resp_bits_data : dmem_resp_bits_data, 32'(k + 1));
            step;
        end
        mem_resp_valid = 1'b0;
        check("inter_out0", outstanding, 0);

        // orphan response
        mem_resp_valid = 1'b1;
        #1;
        check("orphan_iresp", imem_resp_valid, 0);
        check("orphan_dresp", dmem_resp_valid, 0);
        step;
        mem_resp_valid = 1'b0;
        check("orphan_err", resp_err, 1);
        check("orphan_out", outstanding, 0);
        dmem_req_valid = 1'b1;
        step;
        dmem_req_valid = 1'b0;
        step;
        check("orphan_sticky", resp_err, 1);
        check("orphan_out1", outstanding, 1);

        // reset mid-operation drops the owner; the late response becomes an orphan
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("midrst_out", outstanding, 0);
        check("midrst_err", resp_err, 0);
        mem_resp_valid = 1'b1;
        #1;
        check("midrst_dresp", dmem_resp_valid, 0);
        step;
        mem_resp_valid = 1'b0;
        check("midrst_err_set", resp_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
